// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake plus instruction-memory write port for imem_loader.
// The master modport is the loader side; slave is the stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_waddr,
    output imem_wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_waddr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a little-endian byte stream into 32-bit words,
// holds the core in reset until done. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.master bus,
  output logic          cpu_rst,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    FIN,
    DONE,
    ERR
  } state_t;

  // Where the stream goes once the last data word (or an empty count) is seen.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t LOAD_END = CSUM;
`else
  localparam state_t LOAD_END = FIN;
`endif

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic [15:0] word_cnt;
  logic [15:0] n_words;
  logic [15:0] n_full;
  logic        rx_hs;
  logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign rx_hs     = bus.rx_valid && bus.rx_ready;
  assign n_full    = {bus.rx_data, n_words[7:0]};
  assign last_word = (word_cnt == n_words - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= CNT_LO;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CNT_LO: if (rx_hs) state_nxt = CNT_HI;
      CNT_HI: begin
        if (rx_hs) begin
          if ({1'b0, n_full} > DEPTH_W) state_nxt = ERR;
          else if (n_full == 16'd0)     state_nxt = LOAD_END;
          else                          state_nxt = DATA;
        end
      end
      DATA: if (rx_hs && byte_cnt == 2'd3 && last_word) state_nxt = LOAD_END;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: if (rx_hs) state_nxt = (bus.rx_data == csum) ? FIN : ERR;
`endif
      FIN:     state_nxt = DONE;
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    bus.rx_ready = 1'b0;
    cpu_rst      = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    case (state)
      CNT_LO, CNT_HI, DATA: bus.rx_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: bus.rx_ready = 1'b1;
`endif
      DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

  // Bytes shift in from the top so that after three bytes word_buf = {b2,b1,b0}.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt       <= 2'd0;
      word_buf       <= 24'd0;
      word_cnt       <= 16'd0;
      n_words        <= 16'd0;
      bus.imem_we    <= 1'b0;
      bus.imem_waddr <= '0;
      bus.imem_wdata <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum           <= 8'd0;
`endif
    end else begin
      bus.imem_we <= 1'b0;
      if (rx_hs) begin
        case (state)
          CNT_LO: n_words[7:0]  <= bus.rx_data;
          CNT_HI: n_words[15:8] <= bus.rx_data;
          DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            word_buf <= {bus.rx_data, word_buf[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ bus.rx_data;
`endif
            if (byte_cnt == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_waddr <= word_cnt[ADDR_W-1:0];
              bus.imem_wdata <= {bus.rx_data, word_buf};
              word_cnt       <= word_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
